// File: rtl/exec_control_if.sv
// Bus bundle between the exec_control sequencer and its surroundings:
// program memory, data memory and the ALU. The sequencer is the master.
interface exec_control_if #(
    parameter int PC_WIDTH      = 8,
    parameter int DM_ADDR_WIDTH = 4
);
    // Program memory (synchronous read, data valid one cycle after address)
    logic [PC_WIDTH-1:0]      pm_addr;
    logic [11:0]              pm_data;

    // Data memory (synchronous read, single-cycle write strobe)
    logic [DM_ADDR_WIDTH-1:0] dm_addr;
    logic [7:0]               dm_rdata;
    logic [7:0]               dm_wdata;
    logic                     dm_we;

    // ALU operand/control side and its results; flags are {Z,C,S,O}
    logic                     alu_enable;
    logic [3:0]               alu_mode;
    logic [7:0]               alu_op1;
    logic [7:0]               alu_op2;
    logic [3:0]               alu_cflags;
    logic [7:0]               alu_result;
    logic [3:0]               alu_flags;

    modport master (
        output pm_addr,
        input  pm_data,
        output dm_addr,
        input  dm_rdata,
        output dm_wdata,
        output dm_we,
        output alu_enable,
        output alu_mode,
        output alu_op1,
        output alu_op2,
        output alu_cflags,
        input  alu_result,
        input  alu_flags
    );

    modport slave (
        input  pm_addr,
        output pm_data,
        input  dm_addr,
        output dm_rdata,
        input  dm_wdata,
        input  dm_we,
        input  alu_enable,
        input  alu_mode,
        input  alu_op1,
        input  alu_op2,
        input  alu_cflags,
        output alu_result,
        output alu_flags
    );
endinterface

// File: rtl/exec_control.sv
// Multi-cycle fetch/decode/execute sequencer in front of the ALU.
// Owns PC, IR, accumulator and status register. ALU ops take five cycles
// (FETCH, DECODE, LOAD, EXECUTE, WRITEBACK); all others take three
// (FETCH, DECODE, WRITEBACK). Instruction encoding (IR[11:0]):
//   1mmm mD.. aaaa : ALU op, mode m, D=1 stores to mem[a] instead of Acc
//   01ss tttt tttt : jump to t if SR bit s is set (00 Z, 01 C, 10 S, 11 O)
//   0000 xxxx xxxx : NOP
//   0001 tttt tttt : JMP t
//   0010 iiii iiii : LDI i
//   0011 xxxx xxxx : HALT
module exec_control #(
    parameter int                 PC_WIDTH      = 8,
    parameter int                 DM_ADDR_WIDTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_run,
    exec_control_if.master io_bus,
    output logic [7:0]    o_acc,
    output logic          o_halted
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_LOAD      = 3'd3;
    localparam logic [2:0] S_EXECUTE   = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_HALT      = 3'd6;

    logic [2:0]          r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [11:0]         r_ir;
    logic [7:0]          r_acc;
    logic [3:0]          r_sr;      // {Z,C,S,O}
    logic [7:0]          r_result;  // ALU result captured at end of EXECUTE
    logic [3:0]          r_flags;   // ALU flags captured at end of EXECUTE

    logic [2:0]          w_next_state;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic                w_is_alu;
    logic                w_to_mem;
    logic                w_is_ldi;
    logic                w_is_halt;
    logic                w_cond_bit;

    // Decode of the latched instruction; only meaningful from LOAD onwards.
    assign w_is_alu  = r_ir[11];
    assign w_to_mem  = r_ir[6];
    assign w_is_ldi  = (r_ir[11:8] == 4'b0010);
    assign w_is_halt = (r_ir[11:8] == 4'b0011);
    assign w_pc_inc  = r_pc + PC_WIDTH'(1);
    assign w_target  = PC_WIDTH'(r_ir[7:0]);

    // Bus outputs are pure decodes of state and registers.
    assign io_bus.pm_addr    = r_pc;
    assign io_bus.dm_addr    = DM_ADDR_WIDTH'(r_ir[3:0]);
    assign io_bus.dm_wdata   = r_result;
    assign io_bus.dm_we      = (r_state == S_WRITEBACK) && w_is_alu && w_to_mem;
    assign io_bus.alu_enable = (r_state == S_EXECUTE);
    assign io_bus.alu_mode   = r_ir[10:7];
    assign io_bus.alu_op1    = r_acc;
    assign io_bus.alu_op2    = io_bus.dm_rdata;
    assign io_bus.alu_cflags = r_sr;
    assign o_acc             = r_acc;
    assign o_halted          = (r_state == S_HALT);

    // Select the SR bit tested by a conditional jump.
    always_comb begin
        // NOTE: assign a default first so no path leaves the output unassigned (no latch).
        w_cond_bit = 1'b0;
        case (r_ir[9:8])
            2'b00:   w_cond_bit = r_sr[3];
            2'b01:   w_cond_bit = r_sr[2];
            2'b10:   w_cond_bit = r_sr[1];
            default: w_cond_bit = r_sr[0];
        endcase
    end

    // PC value committed at the end of WRITEBACK.
    always_comb begin
        w_pc_next = w_pc_inc;
        if (!w_is_alu) begin
            if (r_ir[10]) begin
                if (w_cond_bit) begin
                    w_pc_next = w_target;
                end
            end else begin
                case (r_ir[9:8])
                    2'b01:   w_pc_next = w_target;
                    2'b11:   w_pc_next = r_pc;
                    default: w_pc_next = w_pc_inc;
                endcase
            end
        end
    end

    // Sequencer next state; Run is only consulted when leaving IDLE or WRITEBACK.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (i_run) w_next_state = S_FETCH;
            S_FETCH:     w_next_state = S_DECODE;
            S_DECODE:    w_next_state = io_bus.pm_data[11] ? S_LOAD : S_WRITEBACK;
            S_LOAD:      w_next_state = S_EXECUTE;
            S_EXECUTE:   w_next_state = S_WRITEBACK;
            S_WRITEBACK: begin
                if (!w_is_alu && w_is_halt) begin
                    w_next_state = S_HALT;
                end else if (i_run) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_HALT:      w_next_state = S_HALT;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // State and architectural registers; reset aborts any instruction in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_acc    <= '0;
            r_sr     <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_state <= w_next_state;
            case (r_state)
                S_DECODE: r_ir <= io_bus.pm_data;
                S_EXECUTE: begin
                    r_result <= io_bus.alu_result;
                    r_flags  <= io_bus.alu_flags;
                end
                S_WRITEBACK: begin
                    r_pc <= w_pc_next;
                    if (w_is_alu) begin
                        r_sr <= r_flags;
                        if (!w_to_mem) begin
                            r_acc <= r_result;
                        end
                    end else if (w_is_ldi) begin
                        r_acc <= r_ir[7:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_control.sv
// Self-checking bench for exec_control: behavioural program/data memories,
// an ALU stub, and an instruction-level reference model compared every cycle.
module tb_exec_control;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       run      = 1'b0;
    logic       load_mem = 1'b0;
    logic [7:0] acc;
    logic       halted;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] pm     [256];
    logic [7:0]  dm     [16];
    logic [7:0]  dm_img [16];
    logic [7:0]  m_dm   [16];

    always #5 clk = ~clk;

    exec_control_if #(.PC_WIDTH(8), .DM_ADDR_WIDTH(4)) bus ();

    exec_control #(.PC_WIDTH(8), .DM_ADDR_WIDTH(4), .RESET_PC(8'h00)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_run    (run),
        .io_bus   (bus),
        .o_acc    (acc),
        .o_halted (halted)
    );

    // ALU stub: returns {flags[3:0], result[7:0]}, flags are {Z,C,S,O}.
    function automatic logic [11:0] alu_fn(input logic [3:0] mode, input logic [7:0] a,
                                           input logic [7:0] b, input logic [3:0] cf);
        logic [8:0] s;
        case (mode)
            4'd0:    s = {1'b0, a} + {1'b0, b};
            4'd1:    s = {1'b0, a} - {1'b0, b};
            4'd2:    s = {1'b0, a & b};
            4'd3:    s = {1'b0, a | b};
            4'd4:    s = {1'b0, a ^ b};
            default: s = {cf[2], a ^ {mode, cf}};
        endcase
        return {(s[7:0] == 8'h00), s[8], s[7], a[7] ^ b[7] ^ s[7] ^ s[8], s[7:0]};
    endfunction

    // Memories and ALU surrounding the DUT.
    always @(posedge clk) bus.pm_data <= pm[bus.pm_addr];

    always @(posedge clk) begin
        bus.dm_rdata <= dm[bus.dm_addr];
        if (load_mem) begin
            for (int i = 0; i < 16; i++) dm[i] <= dm_img[i];
        end else if (bus.dm_we) begin
            dm[bus.dm_addr] <= bus.dm_wdata;
        end
    end

    always_comb {bus.alu_flags, bus.alu_result} =
        alu_fn(bus.alu_mode, bus.alu_op1, bus.alu_op2, bus.alu_cflags);

    // ---------------- reference model ----------------
    // k counts the cycle within the current instruction (0 = parked).
    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  acc;
        logic [3:0]  sr;
        logic        halted;
        int          k;
        logic [11:0] ir;
    } mstate_t;

    mstate_t    m;
    logic       exp_en;
    logic       exp_we;
    logic [11:0] exp_f;

    function automatic mstate_t model_reset();
        mstate_t s;
        s.pc = 8'h00; s.acc = 8'h00; s.sr = 4'h0; s.halted = 1'b0; s.k = 0; s.ir = 12'h000;
        return s;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic run_in);
        mstate_t     n = s;
        logic [11:0] f;
        int          len = s.ir[11] ? 5 : 3;
        if (s.halted) return n;
        if (s.k == 0) begin
            if (run_in) begin
                n.k  = 1;
                n.ir = pm[s.pc];
            end
        end else if (s.k < len) begin
            n.k = s.k + 1;
        end else begin
            if (s.ir[11]) begin
                f    = alu_fn(s.ir[10:7], s.acc, m_dm[s.ir[3:0]], s.sr);
                n.sr = f[11:8];
                if (!s.ir[6]) n.acc = f[7:0];
                n.pc = s.pc + 8'd1;
            end else if (s.ir[10]) begin
                n.pc = s.sr[3 - int'(s.ir[9:8])] ? s.ir[7:0] : s.pc + 8'd1;
            end else begin
                case (s.ir[9:8])
                    2'b00: n.pc = s.pc + 8'd1;
                    2'b01: n.pc = s.ir[7:0];
                    2'b10: begin n.acc = s.ir[7:0]; n.pc = s.pc + 8'd1; end
                    default: n.halted = 1'b1;
                endcase
            end
            if (n.halted || !run_in) begin
                n.k = 0;
            end else begin
                n.k  = 1;
                n.ir = pm[n.pc];
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_next(m, run);
    end

    always_comb begin
        exp_f  = alu_fn(m.ir[10:7], m.acc, m_dm[m.ir[3:0]], m.sr);
        exp_en = m.ir[11] && (m.k == 4);
        exp_we = m.ir[11] && m.ir[6] && (m.k == 5);
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) m_dm[i] <= dm_img[i];
        end else if (exp_we) begin
            m_dm[m.ir[3:0]] <= exp_f[7:0];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("pm_addr", 32'(bus.pm_addr), 32'(m.pc));
        check("acc", 32'(acc), 32'(m.acc));
        check("sr", 32'(bus.alu_cflags), 32'(m.sr));
        check("halted", 32'(halted), 32'(m.halted));
        check("alu_enable", 32'(bus.alu_enable), 32'(exp_en));
        check("dm_we", 32'(bus.dm_we), 32'(exp_we));
        if (exp_en) begin
            check("alu_mode", 32'(bus.alu_mode), 32'(m.ir[10:7]));
            check("alu_op1", 32'(bus.alu_op1), 32'(m.acc));
            check("alu_op2", 32'(bus.alu_op2), 32'(m_dm[m.ir[3:0]]));
        end
        if (exp_we) check("dm_wdata", 32'(bus.dm_wdata), 32'(exp_f[7:0]));
        if (m.ir[11] && m.k >= 3) check("dm_addr", 32'(bus.dm_addr), 32'(m.ir[3:0]));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        run = 1'b0;
    endtask

    task automatic load_and_release();
        load_mem = 1'b1;
        repeat (2) @(negedge clk);
        #1 load_mem = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;
    endtask

    function automatic logic [11:0] rand_instr();
        int         r = $urandom_range(0, 15);
        logic [7:0] b = 8'($urandom);
        if (r < 8)       return {1'b1, 11'($urandom)};
        else if (r < 10) return {2'b01, 2'($urandom), b};
        else if (r == 10) return {4'b0001, b};
        else if (r < 13) return {4'b0010, b};
        else if (r < 15) return {4'b0000, b};
        else if ($urandom_range(0, 19) == 0) return {4'b0011, b};
        else return {4'b0010, b};
    endfunction

    initial begin
        // Directed program: LDI, ALU add to Acc, ALU store, Z jump, wrap.
        begin_reset();
        for (int i = 0; i < 256; i++) pm[i] = 12'h000;
        for (int i = 0; i < 16; i++) dm_img[i] = 8'($urandom);
        dm_img[3] = 8'h0A; dm_img[4] = 8'h00; dm_img[5] = 8'h01;
        pm[8'h00] = 12'h205; pm[8'h01] = 12'h803; pm[8'h02] = 12'h205;
        pm[8'h03] = 12'h843; pm[8'h04] = 12'h200; pm[8'h05] = 12'h804;
        pm[8'h06] = 12'h4A0; pm[8'hA0] = 12'h805; pm[8'hA1] = 12'h4A0;
        pm[8'hA2] = 12'h1FF; pm[8'hFF] = 12'h000;
        load_and_release();
        tick(1); check("d_fetch_addr", 32'(bus.pm_addr), 32'h00);
                 check("d_fetch_en", 32'(bus.alu_enable), 32'h0);
        tick(3); check("d_ldi_acc", 32'(acc), 32'h05);
                 check("d_ldi_pc", 32'(bus.pm_addr), 32'h01);
                 check("d_ldi_sr", 32'(bus.alu_cflags), 32'h0);
        tick(3); check("d_add_en", 32'(bus.alu_enable), 32'h1);
                 check("d_add_op1", 32'(bus.alu_op1), 32'h05);
                 check("d_add_op2", 32'(bus.alu_op2), 32'h0A);
                 check("d_add_mode", 32'(bus.alu_mode), 32'h0);
        tick(1); check("d_add_wb_en", 32'(bus.alu_enable), 32'h0);
                 check("d_add_wb_acc", 32'(acc), 32'h05);
        tick(1); check("d_add_acc", 32'(acc), 32'h0F);
                 check("d_add_pc", 32'(bus.pm_addr), 32'h02);
        tick(3); check("d_ldi2_acc", 32'(acc), 32'h05);
        tick(4); check("d_st_we", 32'(bus.dm_we), 32'h1);
                 check("d_st_addr", 32'(bus.dm_addr), 32'h3);
                 check("d_st_wdata", 32'(bus.dm_wdata), 32'h0F);
                 check("d_st_acc", 32'(acc), 32'h05);
        tick(1); check("d_st_we_off", 32'(bus.dm_we), 32'h0);
                 check("d_st_pc", 32'(bus.pm_addr), 32'h04);
                 check("d_st_mem", 32'(dm[3]), 32'h0F);
        tick(3); check("d_ldi0_acc", 32'(acc), 32'h00);
        tick(5); check("d_zero_sr", 32'(bus.alu_cflags), 32'h8);
        tick(3); check("d_jz_taken", 32'(bus.pm_addr), 32'hA0);
        tick(5); check("d_add1_acc", 32'(acc), 32'h01);
                 check("d_add1_sr", 32'(bus.alu_cflags), 32'h0);
        tick(3); check("d_jz_not", 32'(bus.pm_addr), 32'hA2);
        tick(3); check("d_jmp_ff", 32'(bus.pm_addr), 32'hFF);
        tick(3); check("d_pc_wrap", 32'(bus.pm_addr), 32'h00);
        tick(3); check("d_rerun_pc", 32'(bus.pm_addr), 32'h01);
        // Drop Run while the next ALU op sits in LOAD.
        tick(2); check("d_load_en", 32'(bus.alu_enable), 32'h0);
                 check("d_load_addr", 32'(bus.dm_addr), 32'h3);
        #1 run = 1'b0;
        tick(3); check("d_drop_acc", 32'(acc), 32'h14);
                 check("d_drop_pc", 32'(bus.pm_addr), 32'h02);
        tick(5); check("d_idle_pc", 32'(bus.pm_addr), 32'h02);
                 check("d_idle_en", 32'(bus.alu_enable), 32'h0);

        // HALT holds forever with Run high.
        begin_reset();
        pm[8'h00] = 12'h300;
        load_and_release();
        tick(1); check("h_fetch_halted", 32'(halted), 32'h0);
        tick(3); check("h_halted", 32'(halted), 32'h1);
                 check("h_pc", 32'(bus.pm_addr), 32'h00);
        tick(100);
        check("h_still_halted", 32'(halted), 32'h1);
        check("h_still_pc", 32'(bus.pm_addr), 32'h00);

        // Reset during EXECUTE of a store.
        begin_reset();
        pm[8'h00] = 12'h205; pm[8'h01] = 12'h843;
        dm_img[3] = 8'h33;
        load_and_release();
        tick(4); check("r_acc_before", 32'(acc), 32'h05);
        tick(3); check("r_exec_en", 32'(bus.alu_enable), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("r_acc", 32'(acc), 32'h00);
        check("r_pc", 32'(bus.pm_addr), 32'h00);
        check("r_en", 32'(bus.alu_enable), 32'h0);
        check("r_we", 32'(bus.dm_we), 32'h0);
        check("r_halted", 32'(halted), 32'h0);
        tick(3); check("r_mem_kept", 32'(dm[3]), 32'h33);
                 check("r_we_held", 32'(bus.dm_we), 32'h0);

        // Random programs with random Run gaps and occasional resets.
        for (int it = 0; it < 6; it++) begin
            begin_reset();
            for (int i = 0; i < 256; i++) pm[i] = rand_instr();
            for (int i = 0; i < 16; i++) dm_img[i] = 8'($urandom);
            load_and_release();
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                #1;
                run = ($urandom_range(0, 9) != 0);
                rst = ($urandom_range(0, 399) == 0);
            end
            @(negedge clk);
            for (int i = 0; i < 16; i++) check("rand_mem", 32'(dm[i]), 32'(m_dm[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
